// File: rtl/game_controller_pkg.sv
// ---------------------------------------------------------------------------
// game_controller_pkg
// Shared definitions for the game controller and the pipe generator:
//   - game_state_t : game state encoding. The pipe generator reads it as
//                    0 = clear, 1 = run, 2/3 = freeze.
//   - geometry     : bird and pipe-slot dimensions and the ground line,
//                    all in screen pixels.
//   - cnt_width()  : counter width helper; never returns less than one bit.
// ---------------------------------------------------------------------------
package game_controller_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      DYING = 2'd2,
      OVER  = 2'd3
   } game_state_t;

   localparam int BIRD_HPOS    = 320;
   localparam int BIRD_XWIDTH  = 34;
   localparam int BIRD_YHEIGHT = 24;
   localparam int SLOT_WIDTH   = 60;
   localparam int SLOT_HEIGHT  = 100;
   localparam int GROUND_Y     = 436;   // 480 - 44 rows of land

   // A counter that must reach n-1 needs ceil(log2(n)) bits.
   // Degenerate n <= 1 still gets one bit so the vector stays legal.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/game_controller_btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Brings the raw flap/start button into the clk_2ms domain and debounces it.
// It then emits a one-tick press pulse on each debounced rising edge.
//
// Ports
//   clk_2ms  in   2 ms game tick
//   rst_n    in   asynchronous active-low reset
//   btn_raw  in   unsynchronised button, active high
//   press    out  one-tick pulse per debounced press
//
// The debounced level flips only after DEBOUNCE_TICKS consecutive
// synchronised samples that differ from it. Holding the button gives one
// press, because the pulse comes from the level's edge, not from the level.
// ---------------------------------------------------------------------------
module btn_debounce
   import game_controller_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 5
) (
   input  logic clk_2ms,
   input  logic rst_n,
   input  logic btn_raw,
   output logic press
);

   localparam int             CW       = cnt_width(DEBOUNCE_TICKS);
   localparam logic [CW-1:0]  C_RELOAD = CW'(DEBOUNCE_TICKS - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_level_d;
   logic [CW-1:0] r_cnt;

   // r_cnt is a down-counter of the differing samples still needed.
   // Any sample that agrees with the current level reloads it, so only an
   // unbroken run reaches terminal count. The sample that finds r_cnt at
   // zero is the DEBOUNCE_TICKS-th in the run, and it flips the level.
   always_ff @(posedge clk_2ms or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_cnt     <= '0;
      end else begin
         r_sync1   <= btn_raw;
         r_sync2   <= r_sync1;
         r_level_d <= r_level;
         if (r_sync2 == r_level) begin
            r_cnt <= C_RELOAD;
         end else if (r_cnt == '0) begin
            r_level <= r_sync2;
            r_cnt   <= C_RELOAD;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign press = r_level & ~r_level_d;

endmodule

// File: rtl/game_controller.sv
// ---------------------------------------------------------------------------
// game_controller
// Top-level game sequencer. It debounces the player button, detects
// collisions of the bird with the current pipe or the ground, and runs the
// IDLE/PLAY/DYING/OVER flow. It also commands flaps and keeps the best score.
//
// Ports
//   clk_2ms     in   2 ms game tick, the only clock
//   rst_n       in   asynchronous active-low reset
//   btn_raw     in   raw flap/start button, active high
//   bird_Y      in   [8:0] bird top-edge row
//   pip_X       in   [9:0] pipe right edge (0..724)
//   pip_Y       in   [8:0] bottom row of the pipe gap
//   score       in   [7:0] current score from the pipe generator
//   state       out  [1:0] game state, drives the pipe generator
//   flap        out  one-tick jump command
//   best_score  out  [7:0] highest score reached since reset
//
// State table
//   state | meaning
//   IDLE  | waiting for a press; the pipe generator is cleared
//   PLAY  | game running; each press flaps, a collision kills the bird
//   DYING | frozen for DYING_TICKS ticks; presses are ignored
//   OVER  | frozen; a press returns to IDLE
// ---------------------------------------------------------------------------
module game_controller
   import game_controller_pkg::game_state_t;
   import game_controller_pkg::IDLE;
   import game_controller_pkg::PLAY;
   import game_controller_pkg::DYING;
   import game_controller_pkg::OVER;
   import game_controller_pkg::cnt_width;
#(
   parameter int BIRD_HPOS      = game_controller_pkg::BIRD_HPOS,
   parameter int BIRD_XWIDTH    = game_controller_pkg::BIRD_XWIDTH,
   parameter int BIRD_YHEIGHT   = game_controller_pkg::BIRD_YHEIGHT,
   parameter int SLOT_WIDTH     = game_controller_pkg::SLOT_WIDTH,
   parameter int SLOT_HEIGHT    = game_controller_pkg::SLOT_HEIGHT,
   parameter int GROUND_Y       = game_controller_pkg::GROUND_Y,
   parameter int DEBOUNCE_TICKS = 5,
   parameter int DYING_TICKS    = 250
) (
   input  logic       clk_2ms,
   input  logic       rst_n,
   input  logic       btn_raw,
   input  logic [8:0] bird_Y,
   input  logic [9:0] pip_X,
   input  logic [8:0] pip_Y,
   input  logic [7:0] score,
   output logic [1:0] state,
   output logic       flap,
   output logic [7:0] best_score
);

   localparam int             DW           = cnt_width(DYING_TICKS);
   localparam logic [DW-1:0]  C_DEATH_LAST = DW'(DYING_TICKS - 1);

   // Pipe overlaps the bird column when HPOS < pip_X < HPOS+XWIDTH+SLOT_WIDTH.
   // SLOT_WIDTH is moved across the compare so nothing is subtracted from
   // pip_X. Likewise the gap-top test adds SLOT_HEIGHT to bird_Y instead of
   // subtracting it from pip_Y.
   localparam logic [10:0] C_XMIN   = 11'(BIRD_HPOS);
   localparam logic [10:0] C_XMAX   = 11'(BIRD_HPOS + BIRD_XWIDTH + SLOT_WIDTH);
   localparam logic [10:0] C_YH     = 11'(BIRD_YHEIGHT);
   localparam logic [10:0] C_SLOT_H = 11'(SLOT_HEIGHT);
   localparam logic [10:0] C_GROUND = 11'(GROUND_Y);

   logic            w_press;
   logic [10:0]     w_pip_x;
   logic [10:0]     w_pip_y;
   logic [10:0]     w_bird_top;
   logic [10:0]     w_bird_bot;
   logic [10:0]     w_bird_pad;
   logic            w_hovl;
   logic            w_vmiss;
   logic            w_pipe_hit;
   logic            w_ground_hit;
   logic            w_hit;

   game_state_t     r_state;
   logic            r_flap;
   logic [7:0]      r_best;
   logic [DW-1:0]   r_death_cnt;

   game_state_t     w_state_nxt;
   logic            w_flap_nxt;
   logic [7:0]      w_best_nxt;
   logic [DW-1:0]   w_death_nxt;

   btn_debounce #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) u_btn_debounce (
      .clk_2ms (clk_2ms),
      .rst_n   (rst_n),
      .btn_raw (btn_raw),
      .press   (w_press)
   );

   // Collision detect. The geometry is widened to 11 bits so that no sum wraps.
   assign w_pip_x      = {1'b0, pip_X};
   assign w_pip_y      = {2'b00, pip_Y};
   assign w_bird_top   = {2'b00, bird_Y};
   assign w_bird_bot   = w_bird_top + C_YH;
   assign w_bird_pad   = w_bird_top + C_SLOT_H;

   assign w_hovl       = (w_pip_x > C_XMIN) && (w_pip_x < C_XMAX);
   assign w_vmiss      = (w_bird_pad < w_pip_y) || (w_bird_bot > w_pip_y);
   assign w_pipe_hit   = w_hovl && w_vmiss;
   assign w_ground_hit = (w_bird_bot >= C_GROUND);
   assign w_hit        = w_pipe_hit || w_ground_hit;

   always_ff @(posedge clk_2ms or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_flap      <= 1'b0;
         r_best      <= 8'd0;
         r_death_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_flap      <= w_flap_nxt;
         r_best      <= w_best_nxt;
         r_death_cnt <= w_death_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_flap_nxt  = 1'b0;
      w_best_nxt  = r_best;
      w_death_nxt = r_death_cnt;
      case (r_state)
         IDLE: begin
            if (w_press) begin
               w_state_nxt = PLAY;
               w_flap_nxt  = 1'b1;
            end
         end
         PLAY: begin
            // A collision beats a press in the same tick: the bird dies
            // without flapping.
            if (w_hit) begin
               w_state_nxt = DYING;
               w_death_nxt = '0;
               if (score > r_best) begin
                  w_best_nxt = score;
               end
            end else if (w_press) begin
               w_flap_nxt = 1'b1;
            end
         end
         DYING: begin
            w_death_nxt = r_death_cnt + 1'b1;
            if (r_death_cnt == C_DEATH_LAST) begin
               w_state_nxt = OVER;
            end
         end
         OVER: begin
            if (w_press) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign state      = r_state;
   assign flap       = r_flap;
   assign best_score = r_best;

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

   localparam int BIRD_HPOS      = 320;
   localparam int BIRD_XWIDTH    = 34;
   localparam int BIRD_YHEIGHT   = 24;
   localparam int SLOT_WIDTH     = 60;
   localparam int SLOT_HEIGHT    = 100;
   localparam int GROUND_Y       = 436;
   localparam int DEBOUNCE_TICKS = 5;
   localparam int DYING_TICKS    = 250;

   logic       clk_2ms;
   logic       rst_n;
   logic       btn_raw;
   logic [8:0] bird_Y;
   logic [9:0] pip_X;
   logic [8:0] pip_Y;
   logic [7:0] score;
   logic [1:0] state;
   logic       flap;
   logic [7:0] best_score;

   game_controller dut (
      .clk_2ms    (clk_2ms),
      .rst_n      (rst_n),
      .btn_raw    (btn_raw),
      .bird_Y     (bird_Y),
      .pip_X      (pip_X),
      .pip_Y      (pip_Y),
      .score      (score),
      .state      (state),
      .flap       (flap),
      .best_score (best_score)
   );

   initial clk_2ms = 1'b0;
   always #5 clk_2ms = ~clk_2ms;

   int n_checks = 0;
   int n_err    = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Behavioural reference model: game rules written in terms of the
   // button history, run lengths and a tick age.
   int m_state, m_flap, m_best, m_age, m_level, m_run;
   bit m_rise;
   bit m_hist[$];

   function automatic bit geo_hit(input int by, input int px, input int py);
      bit pipe, ground;
      pipe = (px > BIRD_HPOS) && (px - SLOT_WIDTH < BIRD_HPOS + BIRD_XWIDTH) &&
             ((by < py - SLOT_HEIGHT) || (by + BIRD_YHEIGHT > py));
      ground = (by + BIRD_YHEIGHT >= GROUND_Y);
      return pipe || ground;
   endfunction

   task automatic model_reset();
      m_state = 0; m_flap = 0; m_best = 0; m_age = 0;
      m_level = 0; m_run = 0; m_rise = 1'b0;
      m_hist.delete();
      m_hist.push_back(1'b0);
      m_hist.push_back(1'b0);
   endtask

   task automatic model_step();
      bit press, hit, sample;
      press  = m_rise;
      hit    = geo_hit(int'(bird_Y), int'(pip_X), int'(pip_Y));
      m_flap = 0;
      if (m_state == 0) begin
         if (press) begin m_state = 1; m_flap = 1; end
      end else if (m_state == 1) begin
         if (hit) begin
            m_state = 2; m_age = 0;
            if (int'(score) > m_best) m_best = int'(score);
         end else if (press) begin
            m_flap = 1;
         end
      end else if (m_state == 2) begin
         m_age++;
         if (m_age == DYING_TICKS) m_state = 3;
      end else begin
         if (press) m_state = 0;
      end
      // the debouncer sees the button as it was two ticks earlier
      sample = m_hist.pop_front();
      m_hist.push_back(btn_raw);
      m_rise = 1'b0;
      if (int'(sample) != m_level) begin
         m_run++;
         if (m_run == DEBOUNCE_TICKS) begin
            m_level = int'(sample);
            m_run   = 0;
            m_rise  = sample;
         end
      end else begin
         m_run = 0;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_2ms);
      #1;
      chk("model_state", int'(state), m_state);
      chk("model_flap", int'(flap), m_flap);
      chk("model_best", int'(best_score), m_best);
   endtask

   task automatic safe_geo();
      bird_Y = 9'd100; pip_X = 10'd0; pip_Y = 9'd300;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk_2ms);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic press_btn();
      btn_raw = 1'b1;
      repeat (8) tick();
      btn_raw = 1'b0;
      repeat (8) tick();
   endtask

   task automatic wait_state(input int s, input int bound, output int n);
      n = 0;
      while (int'(state) != s && n < bound) begin
         tick();
         n++;
      end
   endtask

   typedef struct {
      int by;
      int px;
      int py;
      int exp_state;
   } vec_t;

   vec_t vecs[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, state=%0d", state);
      $fatal(1, "watchdog");
   end

   initial begin
      int n, flaps, run_left;
      vecs[0]  = '{150, 340, 300, 2};  // above the gap
      vecs[1]  = '{230, 340, 300, 1};  // inside the gap
      vecs[2]  = '{412,   0, 300, 2};  // ground touch
      vecs[3]  = '{411,   0, 300, 1};  // one row above ground
      vecs[4]  = '{150, 320, 300, 1};  // pipe edge at HPOS: no overlap
      vecs[5]  = '{150, 321, 300, 2};
      vecs[6]  = '{150, 414, 300, 1};  // pipe left edge at bird right edge
      vecs[7]  = '{150, 413, 300, 2};
      vecs[8]  = '{199, 340, 300, 2};  // gap top boundary
      vecs[9]  = '{200, 340, 300, 1};
      vecs[10] = '{276, 340, 300, 1};  // gap bottom boundary
      vecs[11] = '{277, 340, 300, 2};
      vecs[12] = '{411, 340, 300, 2};  // below the gap
      vecs[13] = '{  0, 724, 300, 1};  // pipe far right

      rst_n = 1'b0; btn_raw = 1'b0; score = 8'd0;
      safe_geo();
      model_reset();
      repeat (3) @(posedge clk_2ms);
      #1;
      chk("reset_state", int'(state), 0);
      chk("reset_flap", int'(flap), 0);
      chk("reset_best", int'(best_score), 0);
      rst_n = 1'b1;

      // short glitch: no press
      btn_raw = 1'b1;
      repeat (4) tick();
      btn_raw = 1'b0;
      flaps = 0;
      repeat (12) begin tick(); flaps += int'(flap); end
      chk("glitch_state", int'(state), 0);
      chk("glitch_flaps", flaps, 0);

      // long press: start with exactly one flap
      btn_raw = 1'b1;
      flaps = 0;
      repeat (20) begin tick(); flaps += int'(flap); end
      btn_raw = 1'b0;
      repeat (10) begin tick(); flaps += int'(flap); end
      chk("start_state", int'(state), 1);
      chk("start_flaps", flaps, 1);

      // collision vectors, one play session each
      foreach (vecs[i]) begin
         do_reset();
         safe_geo();
         press_btn();
         chk("vec_enter_play", int'(state), 1);
         bird_Y = 9'(vecs[i].by);
         pip_X  = 10'(vecs[i].px);
         pip_Y  = 9'(vecs[i].py);
         tick();
         chk($sformatf("geo_vec%0d", i), int'(state), vecs[i].exp_state);
         safe_geo();
      end

      // hit and press in the same tick
      do_reset();
      safe_geo();
      press_btn();
      btn_raw = 1'b1;
      n = 0;
      while (!m_rise && n < 20) begin tick(); n++; end
      chk("hp_press_arrived", int'(n < 20), 1);
      bird_Y = 9'd412;
      tick();
      chk("hp_state", int'(state), 2);
      chk("hp_flap", int'(flap), 0);
      btn_raw = 1'b0;
      safe_geo();
      wait_state(3, 300, n);
      chk("dying_len", n, DYING_TICKS);

      // best score tracking
      do_reset();
      safe_geo();
      press_btn();
      score = 8'd7;
      bird_Y = 9'd412;
      tick();
      chk("best_first", int'(best_score), 7);
      safe_geo();
      wait_state(3, 300, n);
      chk("best_over1", int'(state), 3);
      press_btn();
      chk("over_to_idle", int'(state), 0);
      press_btn();
      chk("replay", int'(state), 1);
      score = 8'd3;
      bird_Y = 9'd412;
      tick();
      chk("best_hold", int'(best_score), 7);
      safe_geo();
      wait_state(3, 300, n);
      press_btn();
      chk("over_to_idle2", int'(state), 0);

      // async reset in the middle of DYING
      press_btn();
      bird_Y = 9'd412;
      tick();
      safe_geo();
      repeat (10) tick();
      chk("ar_dying", int'(state), 2);
      #2;
      rst_n = 1'b0;
      #1;
      chk("ar_state", int'(state), 0);
      chk("ar_flap", int'(flap), 0);
      chk("ar_best", int'(best_score), 0);
      model_reset();
      @(posedge clk_2ms);
      #1;
      rst_n = 1'b1;
      tick();
      chk("ar_after", int'(state), 0);

      // randomized run against the model
      do_reset();
      safe_geo();
      run_left = 0;
      for (int t = 0; t < 4000; t++) begin
         if (run_left == 0) begin
            btn_raw  = ~btn_raw;
            run_left = int'($urandom_range(1, 12));
         end
         run_left--;
         score = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) == 0) begin
            bird_Y = 9'($urandom_range(0, 511));
            pip_X  = 10'($urandom_range(0, 724));
            pip_Y  = 9'($urandom_range(0, 511));
         end else begin
            safe_geo();
         end
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/game_controller.md
GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- BIRD_HPOS, 320, bird left-edge screen X
- BIRD_XWIDTH, 34, bird width in pixels
- BIRD_YHEIGHT, 24, bird height in pixels
- SLOT_WIDTH, 60, pipe width in pixels
- SLOT_HEIGHT, 100, vertical gap height
- GROUND_Y, 436, top row of land (480 - 44)
- DEBOUNCE_TICKS, 5, stable samples required on the button
- DYING_TICKS, 250, freeze duration (ticks)

REQ-002 SHALL have ports, one per line: name, direction, width, meaning.
- clk_2ms, in, 1, 2 ms game tick; every register uses this clock
- rst_n, in, 1, asynchronous active-low reset
- btn_raw, in, 1, unsynchronised flap/start button, active high
- bird_Y, in, 9, bird top-edge row
- pip_X, in, 10, pipe right edge (0..724) from pipe generator
- pip_Y, in, 9, bottom row of the pipe gap
- score, in, 8, current score from pipe generator
- state, out, 2, game state driven into the pipe generator
- flap, out, 1, one-tick pulse commanding a bird jump
- best_score, out, 8, highest score since reset

REQ-003 SHALL have one clock and an asynchronous, active-low reset: the clock is clk_2ms and the reset is rst_n.

Function
REQ-004 SHALL encode state as IDLE=0, PLAY=1, DYING=2, OVER=3; the pipe generator treats 0 as clear, 1 as run and 2/3 as freeze.
REQ-005 SHALL pass btn_raw through a 2-flop synchroniser, then a debouncer: the debounced level changes only after DEBOUNCE_TICKS consecutive equal synchronised samples.
REQ-006 SHALL derive press as a one-tick pulse on the debounced rising edge; holding the button gives exactly one press.
REQ-007 SHALL define pipe_hit, combinationally, as true when both conditions hold:
- horizontal overlap: pip_X > BIRD_HPOS and pip_X - SLOT_WIDTH < BIRD_HPOS + BIRD_XWIDTH;
- vertical miss: bird_Y < pip_Y - SLOT_HEIGHT, or bird_Y + BIRD_YHEIGHT > pip_Y.
REQ-008 SHALL define ground_hit as bird_Y + BIRD_YHEIGHT >= GROUND_Y; all sums are computed 11 bits wide with no wrap.
REQ-009 SHALL make these transitions:
- IDLE -> PLAY on press, with flap=1 in the same tick as the transition;
- PLAY -> DYING on pipe_hit or ground_hit;
- DYING -> OVER when the death counter reaches DYING_TICKS-1;
- OVER -> IDLE on press.
REQ-010 SHALL, in PLAY, assert flap for one tick on each press when no hit occurs in that tick.
REQ-011 SHALL give a hit priority over a press in the same tick: the next state is DYING and flap=0.
REQ-012 SHALL keep flap=0 in IDLE after entry, in DYING and in OVER, and ignore presses in DYING.
REQ-013 SHALL clear the death counter on entry to DYING and increment it once per tick while in DYING; its width is ceil(log2(DYING_TICKS)).
REQ-014 SHALL, on the PLAY->DYING tick, update best_score with score when score > best_score; otherwise best_score holds.
REQ-015 SHALL register state, flap and best_score; each changes one clk_2ms edge after its cause.

Reset
REQ-016 SHALL force, while rst_n=0 and independent of the clock: state=IDLE, flap=0, best_score=0, death counter=0, synchroniser and debouncer registers=0.
REQ-017 SHALL, on reset asserted mid-PLAY or mid-DYING, return to IDLE immediately; the first clock edge after release evaluates from IDLE.

Structure
REQ-018 SHALL place the state encodings (IDLE/PLAY/DYING/OVER) and the shared geometry constants (BIRD_HPOS, BIRD_XWIDTH, SLOT_WIDTH, SLOT_HEIGHT, GROUND_Y) in a shared package, also used by the pipe generator.
REQ-019 SHALL implement the synchroniser and debouncer as one sub-module, btn_debounce (ports clk_2ms, rst_n, btn_raw, press); collision logic and the FSM stay in game_controller.

Verification
REQ-020 SHALL cover these directed scenarios:
- Press debounce: btn_raw high for 4 ticks then low -> no press, state stays 0; high for 8 ticks -> state 0->1 with exactly one flap pulse.
- Pipe hit: PLAY, pip_X=340, pip_Y=300, bird_Y=150 (above gap 200..300) -> state=2 on the next edge; bird_Y=230 -> state stays 1.
- Ground hit: PLAY, bird_Y=412 -> DYING; bird_Y=411 -> PLAY holds.
- Hit with press: hit and press in the same tick -> state=2, flap=0; state=3 exactly 250 ticks after entering DYING.
- Best score: die at score 7 -> best_score=7; replay, die at score 3 -> best_score stays 7; OVER + press -> state=0.
- Async reset: rst_n low mid-DYING, between clock edges -> state=0, flap=0, best_score=0 before the next clock edge.
